// File: rtl/exec_pkg.sv
// Shared encodings for the execute-stage sequencer: op codes, ALU op codes,
// flag bit positions, decoded control bundle and FSM states.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ADDI = 3'd3,
    OP_CMP  = 3'd4,
    OP_BEQ  = 3'd5,
    OP_BLTU = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_e;

  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  localparam logic [2:0] FMASK_ALL  = 3'b111;
  localparam logic [2:0] FMASK_Z    = 3'b001;
  localparam logic [2:0] FMASK_NONE = 3'b000;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_LTU  = 2'd2
  } br_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       b_imm;      // operand B comes from the sign-extended immediate
    logic       wr_en;
    logic [2:0] flag_mask;  // which flag bits this op loads
    br_e        br;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/exec_op_decode.sv
// Combinational op decoder: maps a 3-bit op to the ALU/writeback/flag controls.
module exec_op_decode
  import exec_pkg::*;
(
  input  logic [2:0] op,
  output dec_t       dec
);

  // Decode table; illegal op writes nothing and touches no flags.
  always_comb begin
    dec.alu_op    = ALU_ADD;
    dec.b_imm     = 1'b0;
    dec.wr_en     = 1'b0;
    dec.flag_mask = FMASK_NONE;
    dec.br        = BR_NONE;
    dec.illegal   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        dec.wr_en     = 1'b1;
        dec.flag_mask = FMASK_Z;
      end
      OP_SUB: begin
        dec.alu_op    = ALU_SUB;
        dec.wr_en     = 1'b1;
        dec.flag_mask = FMASK_ALL;
      end
      OP_AND: begin
        dec.alu_op    = ALU_AND;
        dec.wr_en     = 1'b1;
        dec.flag_mask = FMASK_Z;
      end
      OP_ADDI: begin
        dec.b_imm     = 1'b1;
        dec.wr_en     = 1'b1;
        dec.flag_mask = FMASK_Z;
      end
      OP_CMP: begin
        dec.alu_op    = ALU_SUB;
        dec.flag_mask = FMASK_ALL;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.br     = BR_EQ;
      end
      OP_BLTU: begin
        dec.alu_op = ALU_SUB;
        dec.br     = BR_LTU;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage controller: accepts a command, drives an external ALU from
// registered operands, captures result/flags and hands the result to writeback.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RD_W-1:0]  cmd_rd,
  input  logic [31:0]      cmd_rs_val,
  input  logic [31:0]      cmd_rt_val,
  input  logic [IMM_W-1:0] cmd_imm,
  input  logic             flush,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [RD_W-1:0]  res_rd,
  output logic             res_wr_en,
  output logic             res_taken,
  output logic             res_illegal,
  output logic [2:0]       flags_q
);

  state_e          state_q, state_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  alu_op_e         alu_op_q, alu_op_d;
  logic            wr_q, wr_d;
  logic [2:0]      mask_q, mask_d;
  br_e             br_q, br_d;
  logic            ill_q, ill_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic [31:0]     res_data_q, res_data_d;
  logic [RD_W-1:0] res_rd_q, res_rd_d;
  logic            res_wr_en_q, res_wr_en_d;
  logic            res_taken_q, res_taken_d;
  logic            res_illegal_q, res_illegal_d;
  logic [2:0]      flags_d;

  dec_t        dec;
  logic [31:0] imm_sext;

  exec_op_decode u_decode (
    .op  (cmd_op),
    .dec (dec)
  );

  assign imm_sext = {{(32 - IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};

  // Flush also blocks acceptance so the upstream never sees a dropped handshake.
  assign cmd_ready = (state_q == ST_IDLE) && !reset && !flush;
  assign res_valid = (state_q == ST_DONE);

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = alu_op_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_wr_en   = res_wr_en_q;
  assign res_taken   = res_taken_q;
  assign res_illegal = res_illegal_q;

  // Next-state, operand load on accept, result/flag capture at end of EXEC.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_op_d      = alu_op_q;
    wr_d          = wr_q;
    mask_d        = mask_q;
    br_d          = br_q;
    ill_d         = ill_q;
    rd_d          = rd_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_wr_en_d   = res_wr_en_q;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;
    flags_d       = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d      = cmd_rs_val;
          b_d      = dec.b_imm ? imm_sext : cmd_rt_val;
          alu_op_d = dec.alu_op;
          wr_d     = dec.wr_en;
          mask_d   = dec.flag_mask;
          br_d     = dec.br;
          ill_d    = dec.illegal;
          rd_d     = cmd_rd;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          res_data_d    = ill_q ? '0 : alu_result;
          res_rd_d      = rd_q;
          res_wr_en_d   = wr_q;
          res_illegal_d = ill_q;
          case (br_q)
            BR_EQ:   res_taken_d = alu_flags[FLAG_ZERO];
            BR_LTU:  res_taken_d = alu_flags[FLAG_CARRY];
            default: res_taken_d = 1'b0;
          endcase
          flags_d = (flags_q & ~mask_q) | (alu_flags & mask_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and holding registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      alu_op_q      <= ALU_ADD;
      wr_q          <= 1'b0;
      mask_q        <= '0;
      br_q          <= BR_NONE;
      ill_q         <= 1'b0;
      rd_q          <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_wr_en_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      flags_q       <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      alu_op_q      <= alu_op_d;
      wr_q          <= wr_d;
      mask_q        <= mask_d;
      br_q          <= br_d;
      ill_q         <= ill_d;
      rd_q          <= rd_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_wr_en_q   <= res_wr_en_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
      flags_q       <= flags_d;
    end
  end

endmodule
